// File: rtl/ds18b20_slave.sv
// DS18B20 1-Wire responder: reset/presence, SKIP ROM, CONVERT T, READ SCRATCHPAD.
// Define DS18B20_SLAVE_CRC_EN to emit a real Dallas CRC8 as scratchpad byte 8 (0x00 otherwise).
module ds18b20_slave #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int RST_MIN_US   = 400,
  parameter int PRES_WAIT_US = 30,
  parameter int PRES_LEN_US  = 120,
  parameter int SAMPLE_US    = 30,
  parameter int HOLD_US      = 30,
  parameter int T_CONV_US    = 750_000
) (
  input  logic        clk,
  input  logic        rst_n,
  inout  wire         dq,
  input  logic [15:0] temp_in,
  output logic        conv_busy,
  output logic [7:0]  cmd_byte,
  output logic        cmd_err
);

  localparam int DIV    = (CLK_FREQ / 1_000_000 > 0) ? CLK_FREQ / 1_000_000 : 1;
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CONV_W = (T_CONV_US > 1) ? $clog2(T_CONV_US) : 1;
  localparam int EL_W   = 16;

  localparam logic [DIV_W-1:0]  DIV_LAST       = DIV_W'(DIV - 1);
  localparam logic [CONV_W-1:0] CONV_LAST      = CONV_W'(T_CONV_US - 1);
  localparam logic [EL_W-1:0]   RST_MIN        = EL_W'(RST_MIN_US);
  localparam logic [EL_W-1:0]   PRES_WAIT_LAST = EL_W'(PRES_WAIT_US - 1);
  localparam logic [EL_W-1:0]   PRES_LEN_LAST  = EL_W'(PRES_LEN_US - 1);
  localparam logic [EL_W-1:0]   SAMPLE_AT      = EL_W'(SAMPLE_US);
  localparam logic [EL_W-1:0]   HOLD_END       = EL_W'(HOLD_US);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRES_WAIT = 3'd1;
  localparam logic [2:0] ST_PRES_DRV  = 3'd2;
  localparam logic [2:0] ST_ROM_CMD   = 3'd3;
  localparam logic [2:0] ST_FUNC_CMD  = 3'd4;
  localparam logic [2:0] ST_TX_SCR    = 3'd5;
  localparam logic [2:0] ST_POLL      = 3'd6;
  localparam logic [2:0] ST_HALT      = 3'd7;

  logic              meta_q, sync_q0, sync_q1;
  logic [DIV_W-1:0]  div_q;
  logic [EL_W-1:0]   el_q;
  logic              us_tick, fall, rise, bus_rst;

  logic [2:0]        state_q, state_d;
  logic [EL_W-1:0]   tmr_q, tmr_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic              samp_pend_q, samp_pend_d;
  logic              byte_done_q, byte_done_d;
  logic [3:0]        byte_idx_q, byte_idx_d;
  logic              hold_q, hold_d;
  logic              drive_q, drive_d;
  logic [7:0]        cmd_byte_q, cmd_byte_d;
  logic              cmd_err_q, cmd_err_d;
  logic              conv_start, conv_done;

  logic              conv_busy_q;
  logic [CONV_W-1:0] conv_cnt_q;
  logic [15:0]       temp_q;
  logic [7:0]        scr_byte, crc_byte;

  assign us_tick = (div_q == DIV_LAST);
  assign fall    = sync_q1 & ~sync_q0;
  assign rise    = ~sync_q1 & sync_q0;
  // el_q is the time since the last falling edge, so at a rising edge it is the low width.
  assign bus_rst = rise && (el_q >= RST_MIN);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q0 <= 1'b1;
      sync_q1 <= 1'b1;
      div_q   <= '0;
      el_q    <= '0;
    end else begin
      meta_q  <= dq;
      sync_q0 <= meta_q;
      sync_q1 <= sync_q0;
      div_q   <= us_tick ? '0 : div_q + 1'b1;
      if (fall)
        el_q <= '0;
      else if (us_tick && (el_q != '1))
        el_q <= el_q + 1'b1;
    end
  end

  always_comb begin
    scr_byte = crc_byte;
    case (byte_idx_q)
      4'd0:    scr_byte = temp_q[7:0];
      4'd1:    scr_byte = temp_q[15:8];
      4'd2:    scr_byte = 8'h4B;
      4'd3:    scr_byte = 8'h46;
      4'd4:    scr_byte = 8'h7F;
      4'd5:    scr_byte = 8'hFF;
      4'd6:    scr_byte = 8'h0C;
      4'd7:    scr_byte = 8'h10;
      default: scr_byte = crc_byte;
    endcase
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    samp_pend_d = samp_pend_q;
    byte_done_d = 1'b0;
    byte_idx_d  = byte_idx_q;
    hold_d      = hold_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_err_d   = cmd_err_q;
    conv_start  = 1'b0;

    if (hold_q && (el_q >= HOLD_END))
      hold_d = 1'b0;
    if (byte_done_q)
      cmd_byte_d = sh_q;

    if (bus_rst) begin
      state_d     = ST_PRES_WAIT;
      tmr_d       = '0;
      bit_cnt_d   = '0;
      samp_pend_d = 1'b0;
      byte_idx_d  = '0;
      hold_d      = 1'b0;
      cmd_err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_PRES_WAIT: if (us_tick) begin
          if (tmr_q == PRES_WAIT_LAST) begin
            state_d = ST_PRES_DRV;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_PRES_DRV: if (us_tick) begin
          if (tmr_q == PRES_LEN_LAST) begin
            state_d     = ST_ROM_CMD;
            tmr_d       = '0;
            bit_cnt_d   = '0;
            samp_pend_d = 1'b0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_ROM_CMD, ST_FUNC_CMD: begin
          if (fall) begin
            samp_pend_d = 1'b1;
          end else if (samp_pend_q && (el_q == SAMPLE_AT)) begin
            sh_d        = {sync_q0, sh_q[7:1]};
            bit_cnt_d   = bit_cnt_q + 3'd1;
            samp_pend_d = 1'b0;
            byte_done_d = (bit_cnt_q == 3'd7);
          end
          if (byte_done_q) begin
            if (state_q == ST_ROM_CMD) begin
              if (sh_q == 8'hCC) begin
                state_d = ST_FUNC_CMD;
              end else begin
                cmd_err_d = 1'b1;
                state_d   = ST_HALT;
              end
            end else if (sh_q == 8'h44) begin
              conv_start = 1'b1;
              state_d    = ST_POLL;
            end else if (sh_q == 8'hBE) begin
              state_d    = ST_TX_SCR;
              byte_idx_d = '0;
              bit_cnt_d  = '0;
            end else begin
              cmd_err_d = 1'b1;
              state_d   = ST_HALT;
            end
          end
        end
        ST_TX_SCR: if (fall) begin
          if (!scr_byte[bit_cnt_q])
            hold_d = 1'b1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_idx_q == 4'd8)
              state_d = ST_IDLE;
            else
              byte_idx_d = byte_idx_q + 4'd1;
          end
        end
        ST_POLL: if (fall && conv_busy_q) hold_d = 1'b1;
        default: ;
      endcase
    end

    drive_d = (state_d == ST_PRES_DRV) | hold_d;
  end

  // Async reset clears drive_q immediately, releasing dq mid-slot without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      samp_pend_q <= 1'b0;
      byte_done_q <= 1'b0;
      byte_idx_q  <= '0;
      hold_q      <= 1'b0;
      drive_q     <= 1'b0;
      cmd_byte_q  <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_pend_q <= samp_pend_d;
      byte_done_q <= byte_done_d;
      byte_idx_q  <= byte_idx_d;
      hold_q      <= hold_d;
      drive_q     <= drive_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign conv_done = conv_busy_q && us_tick && (conv_cnt_q == CONV_LAST);

  // The conversion runs independently of the bus FSM so a master reset cannot stop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_busy_q <= 1'b0;
      conv_cnt_q  <= '0;
      temp_q      <= 16'h0550;
    end else if (conv_start) begin
      conv_busy_q <= 1'b1;
      conv_cnt_q  <= '0;
    end else if (conv_done) begin
      conv_busy_q <= 1'b0;
      temp_q      <= temp_in;
    end else if (conv_busy_q && us_tick) begin
      conv_cnt_q <= conv_cnt_q + 1'b1;
    end
  end

`ifdef DS18B20_SLAVE_CRC_EN
  logic [7:0]  crc_q;
  logic [5:0]  crc_cnt_q;
  logic        crc_run_q;
  logic [63:0] crc_data;
  logic        crc_fb;

  assign crc_data = {8'h10, 8'h0C, 8'hFF, 8'h7F, 8'h46, 8'h4B, temp_q};
  assign crc_fb   = crc_q[0] ^ crc_data[crc_cnt_q];

  // One bit per clock over bytes 0..7; restarts whenever the temperature changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q     <= '0;
      crc_cnt_q <= '0;
      crc_run_q <= 1'b1;
    end else if (conv_done) begin
      crc_q     <= '0;
      crc_cnt_q <= '0;
      crc_run_q <= 1'b1;
    end else if (crc_run_q) begin
      crc_q     <= {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
      crc_cnt_q <= crc_cnt_q + 6'd1;
      if (crc_cnt_q == 6'd63)
        crc_run_q <= 1'b0;
    end
  end

  assign crc_byte = crc_q;
`else
  assign crc_byte = 8'h00;
`endif

  assign dq        = drive_q ? 1'b0 : 1'bz;
  assign conv_busy = conv_busy_q;
  assign cmd_byte  = cmd_byte_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_ds18b20_slave.sv
// Bench for ds18b20_slave: 1-Wire master tasks, a vector table of command transactions,
// and hand sequences for presence timing, conversion polling, mid-read reset and async reset.
`timescale 1ns/1ps
module tb_ds18b20_slave;

  localparam int CLK_FREQ = 2_000_000;
  localparam int T_CONV   = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_drive = 1'b0;
  logic [15:0] temp_in = 16'h01ED;
  logic        conv_busy;
  logic [7:0]  cmd_byte;
  logic        cmd_err;
  wire         dq;

  pullup (dq);
  assign dq = m_drive ? 1'b0 : 1'bz;

  always #250 clk = ~clk;

  ds18b20_slave #(
    .CLK_FREQ    (CLK_FREQ),
    .RST_MIN_US  (400),
    .PRES_WAIT_US(30),
    .PRES_LEN_US (120),
    .SAMPLE_US   (30),
    .HOLD_US     (30),
    .T_CONV_US   (T_CONV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dq       (dq),
    .temp_in  (temp_in),
    .conv_busy(conv_busy),
    .cmd_byte (cmd_byte),
    .cmd_err  (cmd_err)
  );

  int  n_cmp = 0;
  int  n_bad = 0;
  time t_rise = 0;
  time t_fall = 0;

  always @(posedge conv_busy) t_rise = $time;
  always @(negedge conv_busy) t_fall = $time;

  typedef struct {
    logic [7:0]  rom;
    logic [7:0]  func;
    int          nbytes;
    logic [63:0] exp;
    logic [7:0]  exp_cmd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

`ifdef DS18B20_SLAVE_CRC_EN
  function automatic logic [7:0] crc8(input logic [63:0] d);
    logic [7:0] c = 8'h00;
    logic       fb;
    for (int i = 0; i < 64; i++) begin
      fb = c[0] ^ d[i];
      c  = {1'b0, c[7:1]} ^ (fb ? 8'h8C : 8'h00);
    end
    return c;
  endfunction
`endif

  // Byte i of the scratchpad; bytes 0..7 are packed LSB-first in d.
  function automatic logic [7:0] exp_byte(input logic [63:0] d, input int i);
    if (i < 8) return d[8*i +: 8];
`ifdef DS18B20_SLAVE_CRC_EN
    return crc8(d);
`else
    return 8'h00;
`endif
  endfunction

  task automatic wait_us(input int n);
    #(n * 1000);
  endtask

  task automatic bus_reset(input int low_us);
    m_drive = 1'b1;
    wait_us(low_us);
    m_drive = 1'b0;
    wait_us(60);
    check("presence", dq, 1'b0);
    wait_us(140);
  endtask

  task automatic write_bit(input logic b);
    m_drive = 1'b1;
    if (b) begin
      wait_us(5);
      m_drive = 1'b0;
      wait_us(57);
    end else begin
      wait_us(60);
      m_drive = 1'b0;
      wait_us(2);
    end
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) write_bit(v[i]);
  endtask

  task automatic read_bit(output logic b);
    m_drive = 1'b1;
    wait_us(5);
    m_drive = 1'b0;
    wait_us(7);
    b = dq;
    wait_us(50);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  rb;
    logic        bit_v;
    int          budget;
    logic [63:0] scr_new;

    vecs[0] = '{rom: 8'hCC, func: 8'hBE, nbytes: 9, exp: 64'h100C_FF7F_464B_0550,
                exp_cmd: 8'hBE, exp_err: 1'b0};
    vecs[1] = '{rom: 8'h33, func: 8'h00, nbytes: 1, exp: 64'hFFFF_FFFF_FFFF_FFFF,
                exp_cmd: 8'h33, exp_err: 1'b1};
    vecs[2] = '{rom: 8'hCC, func: 8'h55, nbytes: 1, exp: 64'hFFFF_FFFF_FFFF_FFFF,
                exp_cmd: 8'h55, exp_err: 1'b1};
    vecs[3] = '{rom: 8'hCC, func: 8'hBE, nbytes: 2, exp: 64'h100C_FF7F_464B_0550,
                exp_cmd: 8'hBE, exp_err: 1'b0};
    scr_new = 64'h100C_FF7F_464B_01ED;

    #1000;
    rst_n = 1'b1;
    wait_us(2);
    check("rst_dq", dq, 1'b1);
    check("rst_conv_busy", conv_busy, 1'b0);
    check("rst_cmd_byte", cmd_byte, 8'h00);
    check("rst_cmd_err", cmd_err, 1'b0);
    wait_us(20);

    // Presence window relative to the master's release.
    m_drive = 1'b1;
    wait_us(500);
    m_drive = 1'b0;
    wait_us(25);  check("pres_before", dq, 1'b1);
    wait_us(10);  check("pres_start", dq, 1'b0);
    wait_us(110); check("pres_end", dq, 1'b0);
    wait_us(10);  check("pres_after", dq, 1'b1);
    wait_us(40);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(rb);
    check("pres_rom_ok", rb, 8'h50);

    for (int v = 0; v < 4; v++) begin
      bus_reset(500);
      check($sformatf("v%0d_err_clr", v), cmd_err, 1'b0);
      write_byte(vecs[v].rom);
      if (vecs[v].rom == 8'hCC) write_byte(vecs[v].func);
      for (int b = 0; b < vecs[v].nbytes; b++) begin
        read_byte(rb);
        check($sformatf("v%0d_byte%0d", v, b), rb, exp_byte(vecs[v].exp, b));
      end
      check($sformatf("v%0d_cmd_byte", v), cmd_byte, vecs[v].exp_cmd);
      check($sformatf("v%0d_cmd_err", v), cmd_err, vecs[v].exp_err);
    end

    // Conversion with polling, then read back the newly latched temperature.
    bus_reset(500);
    write_byte(8'hCC);
    write_byte(8'h44);
    check("conv_cmd_byte", cmd_byte, 8'h44);
    check("conv_busy_set", conv_busy, 1'b1);
    read_bit(bit_v);
    check("poll_busy", bit_v, 1'b0);
    budget = 0;
    while (conv_busy && budget < 300) begin
      wait_us(1);
      budget++;
    end
    check("conv_done_in_time", conv_busy, 1'b0);
    check_range("conv_len_half_us", int'((t_fall - t_rise) / 500), 198, 201);
    read_bit(bit_v);
    check("poll_done", bit_v, 1'b1);
    bus_reset(500);
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int b = 0; b < 9; b++) begin
      read_byte(rb);
      check($sformatf("conv_byte%0d", b), rb, exp_byte(scr_new, b));
    end

    // A long low in the middle of a scratchpad read restarts the transaction.
    bus_reset(500);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(rb); check("mid_byte0", rb, 8'hED);
    read_byte(rb); check("mid_byte1", rb, 8'h01);
    for (int i = 0; i < 3; i++) read_bit(bit_v);
    bus_reset(600);
    write_byte(8'hCC);
    write_byte(8'hBE);
    for (int b = 0; b < 3; b++) begin
      read_byte(rb);
      check($sformatf("restart_byte%0d", b), rb, exp_byte(scr_new, b));
    end
    check("restart_cmd_byte", cmd_byte, 8'hBE);

    // Asynchronous reset during presence releases dq immediately and restores 85 C.
    wait_us(20);
    m_drive = 1'b1;
    wait_us(500);
    m_drive = 1'b0;
    wait_us(60);
    check("async_pres", dq, 1'b0);
    #100;
    rst_n = 1'b0;
    #1;
    check("async_release", dq, 1'b1);
    #899;
    rst_n = 1'b1;
    wait_us(2);
    check("async_conv_busy", conv_busy, 1'b0);
    check("async_cmd_byte", cmd_byte, 8'h00);
    check("async_cmd_err", cmd_err, 1'b0);
    wait_us(20);
    bus_reset(500);
    write_byte(8'hCC);
    write_byte(8'hBE);
    read_byte(rb); check("async_scr0", rb, 8'h50);
    read_byte(rb); check("async_scr1", rb, 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
